// File: rtl/counter_pkg.sv
// State encodings and default width shared by the counter sequencer.
package counter_pkg;

  localparam int DEF_WIDTH = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/counter_ctrl.sv
// Sequencer driving a loadable up-counter as one-shot/auto-reload timer.
// Optional RUN-state pause input when COUNTER_CTRL_PAUSE_EN is defined.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef COUNTER_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic             reload,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] cnt_out,
  output logic             load,
  output logic             enab,
  output logic [WIDTH-1:0] cnt_in,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] period_q;
  logic             reload_q;
  logic             hit;
  logic             hold;
  logic             latch;

`ifdef COUNTER_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign hit = (cnt_out == period_q);

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_nx = S_LOAD;
          latch    = 1'b1;
        end
      end
      S_LOAD: begin
        state_nx = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (stop)
          state_nx = S_IDLE;
        else if (!hold && hit)
          state_nx = S_DONE;
      end
      S_DONE: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else if (reload_q) begin
          state_nx = S_LOAD;
          latch    = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      period_q <= '0;
      reload_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (latch) begin
        period_q <= period;
        reload_q <= reload;
      end
    end
  end

  // stop gates enab combinationally so the counter freezes on the abort edge
  assign enab   = (state == S_RUN) && !hit && !hold && !stop;
  assign load   = (state == S_LOAD);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign cnt_in = '0;

endmodule
